// File: rtl/udp_tx_pkg.sv
// Shared types and constants for the UDP transmit framer.
package udp_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR0,
    HDR1,
    PAYLOAD
  } state_t;

  localparam int unsigned UDP_HDR_BYTES = 8;
  localparam int unsigned UDP_MAX_LEN   = 65527;

  // Byte-enable mask for the final payload beat; byte0 sits in bit 3.
  function automatic logic [3:0] last_keep(input logic [1:0] rem);
    case (rem)
      2'd1:    return 4'h8;
      2'd2:    return 4'hC;
      2'd3:    return 4'hE;
      default: return 4'hF;
    endcase
  endfunction

endpackage

// File: rtl/udp_tx_framer.sv
// UDP transmit framer: emits an 8-byte big-endian UDP header, then passes
// the payload stream through and ends the frame after ceil(len/4) beats.
// Optional macro UDP_LEN_CHECK_EN: flag (sticky) input tlast disagreeing
// with the configured length on len_err.
module udp_tx_framer
  import udp_tx_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD  = 1472,
  parameter logic [15:0] CHECKSUM_VAL = 16'h0
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic [15:0] cfg_src_port,
  input  logic [15:0] cfg_dst_port,
  input  logic [15:0] cfg_len,
  input  logic        cfg_start,
  output logic        busy,
  output logic        done,
  output logic        cfg_err,
  output logic        len_err,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic [31:0] m_axis_tdata,
  output logic [3:0]  m_axis_tkeep,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast
);

  // A payload larger than the UDP length field can describe is never legal.
  localparam int unsigned MAX_EFF   = (MAX_PAYLOAD > UDP_MAX_LEN) ? UDP_MAX_LEN : MAX_PAYLOAD;
  localparam logic [15:0] MAX_LEN16 = 16'(MAX_EFF);

  state_t      state_q, state_d;
  logic [15:0] src_q, src_d;
  logic [15:0] dst_q, dst_d;
  logic [15:0] len_q, len_d;
  logic [13:0] cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        cfg_err_q, cfg_err_d;

  logic [13:0] beats;
  logic        last_beat;
  logic        payload_hs;

  // Beat count is ceil(len/4); at most 16382, so 14 bits suffice.
  assign beats      = len_q[15:2] + {13'd0, |len_q[1:0]};
  assign last_beat  = (cnt_q == 14'd1);
  assign payload_hs = s_axis_tvalid && m_axis_tready;

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign cfg_err = cfg_err_q;

  // State, latched configuration, beat counter and status pulses.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q   <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Next-state and output decode; header words come from registered config
  // so they stay stable while the sink stalls.
  always_comb begin
    state_d       = state_q;
    src_d         = src_q;
    dst_d         = dst_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    done_d        = 1'b0;
    cfg_err_d     = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          if (cfg_len <= MAX_LEN16) begin
            src_d   = cfg_src_port;
            dst_d   = cfg_dst_port;
            len_d   = cfg_len;
            state_d = HDR0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      HDR0: begin
        m_axis_tdata  = {src_q, dst_q};
        m_axis_tkeep  = 4'hF;
        m_axis_tvalid = 1'b1;
        if (m_axis_tready) state_d = HDR1;
      end
      HDR1: begin
        m_axis_tdata  = {len_q + 16'(UDP_HDR_BYTES), CHECKSUM_VAL};
        m_axis_tkeep  = 4'hF;
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = (len_q == 16'd0);
        if (m_axis_tready) begin
          if (len_q == 16'd0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d   = beats;
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        m_axis_tdata  = s_axis_tdata;
        m_axis_tvalid = s_axis_tvalid;
        s_axis_tready = m_axis_tready;
        m_axis_tlast  = last_beat;
        m_axis_tkeep  = last_beat ? last_keep(len_q[1:0]) : 4'hF;
        if (payload_hs) begin
          cnt_d = cnt_q - 14'd1;
          if (last_beat) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef UDP_LEN_CHECK_EN
  logic len_err_q;

  // Sticky flag: input tlast must be set exactly on the counted final beat.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      len_err_q <= 1'b0;
    end else if (state_q == PAYLOAD && payload_hs && (s_axis_tlast != last_beat)) begin
      len_err_q <= 1'b1;
    end
  end

  assign len_err = len_err_q;
`else
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;
  assign len_err      = 1'b0;
`endif

endmodule

// File: tb/tb_udp_tx_framer.sv
// Scoreboard bench for udp_tx_framer: expected output beats are queued when
// a frame is launched and compared as the DUT hands them off.
module tb_udp_tx_framer;

  logic        clk = 1'b0;
  logic        ARESETN = 1'b0;
  logic [15:0] cfg_src_port = '0, cfg_dst_port = '0, cfg_len = '0;
  logic        cfg_start = 1'b0;
  logic        busy, done, cfg_err, len_err;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tvalid, m_axis_tlast;
  logic        m_axis_tready = 1'b1;

  udp_tx_framer dut (
    .ACLK(clk), .ARESETN(ARESETN),
    .cfg_src_port(cfg_src_port), .cfg_dst_port(cfg_dst_port),
    .cfg_len(cfg_len), .cfg_start(cfg_start),
    .busy(busy), .done(done), .cfg_err(cfg_err), .len_err(len_err),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; logic [3:0] keep; logic last; } beat_t;
  typedef struct { logic [31:0] data; logic last; } pay_t;

  beat_t exp_q[$];
  pay_t  pay_q[$];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, done_cnt = 0, cfg_err_cnt = 0, m_hs_cnt = 0, last_hs_cyc = 0;
  bit s_hs = 0, saw_sready = 0, rand_stall = 0, stalled = 0;
  logic [36:0] prev_out = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference tkeep for the final beat: drop the trailing unused bytes.
  function automatic logic [3:0] model_keep(input int rem);
    if (rem == 0) return 4'hF;
    return ~(4'hF >> rem);
  endfunction

  // Queue expected header/payload beats and the payload the source will send.
  task automatic queue_frame(input logic [15:0] src, input logic [15:0] dst,
                             input logic [15:0] len, input int bad_last);
    int nb;
    logic [31:0] d;
    logic [15:0] ulen;
    ulen = len + 16'd8;
    exp_q.push_back('{{src, dst}, 4'hF, 1'b0});
    exp_q.push_back('{{ulen, 16'h0000}, 4'hF, (len == 16'd0)});
    nb = (int'(len) + 3) / 4;
    for (int i = 0; i < nb; i++) begin
      d = $urandom;
      exp_q.push_back('{d, (i == nb - 1) ? model_keep(int'(len) % 4) : 4'hF, (i == nb - 1)});
      pay_q.push_back('{d, (i == nb - 1) ^ (i == bad_last)});
    end
  endtask

  task automatic launch(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len);
    cfg_src_port = src;
    cfg_dst_port = dst;
    cfg_len      = len;
    cfg_start    = 1'b1;
    tick();
    cfg_start    = 1'b0;
  endtask

  task automatic wait_done(input int prev);
    int n = 0;
    while (done_cnt == prev && n < 2000) begin
      tick();
      n++;
    end
    check("done_seen", 64'(done_cnt != prev), 64'd1);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"},   64'(busy), 64'd0);
    check({tag, "_done"},   64'(done), 64'd0);
    check({tag, "_cfgerr"}, 64'(cfg_err), 64'd0);
    check({tag, "_lenerr"}, 64'(len_err), 64'd0);
    check({tag, "_outs"},   64'({m_axis_tvalid, m_axis_tlast, s_axis_tready, m_axis_tkeep, m_axis_tdata}), 64'd0);
  endtask

  // Cycle counter.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output-ready driver: always ready, or random stalls.
  initial forever begin
    @(posedge clk);
    #1;
    m_axis_tready = rand_stall ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Payload source: holds the head word until it is taken.
  initial forever begin
    @(posedge clk);
    #2;
    if (s_hs && pay_q.size() > 0) pay_q.delete(0);
    if (pay_q.size() > 0) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = pay_q[0].data;
      s_axis_tlast  = pay_q[0].last;
    end else begin
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tlast  = 1'b0;
    end
  end

  // Monitor: scoreboard compare, stall stability, done timing.
  initial forever begin
    @(negedge clk);
    if (!ARESETN) begin
      s_hs    = 0;
      stalled = 0;
    end else begin
      beat_t e;
      s_hs = s_axis_tvalid && s_axis_tready;
      if (s_axis_tready) saw_sready = 1;
      if (stalled && m_axis_tvalid)
        check("stall_hold", 64'({m_axis_tdata, m_axis_tkeep, m_axis_tlast}), 64'(prev_out));
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'(m_axis_tdata), 64'hDEAD_BEEF_0000_0000);
        end else begin
          e = exp_q.pop_front();
          check("beat", 64'({m_axis_tdata, m_axis_tkeep, m_axis_tlast}), 64'({e.data, e.keep, e.last}));
        end
        if (m_axis_tlast) last_hs_cyc = cyc;
        m_hs_cnt++;
      end
      stalled  = m_axis_tvalid && !m_axis_tready;
      prev_out = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
      if (done) begin
        done_cnt++;
        $display("frame %0d done at cycle %0d", done_cnt, cyc);
        check("done_lat", 64'(cyc), 64'(last_hs_cyc + 1));
        check("busy_at_done", 64'(busy), 64'd0);
      end
      if (cfg_err) cfg_err_cnt++;
    end
  end

  initial begin
    int prev, start_cyc, base, n;

    // Reset state.
    repeat (3) tick();
    check_quiet("reset");
    ARESETN = 1'b1;
    tick();

    // 1: len=8, always ready; latency and frame length.
    queue_frame(16'h1234, 16'h5678, 16'd8, -1);
    prev = done_cnt;
    launch(16'h1234, 16'h5678, 16'd8);
    start_cyc = cyc;
    check("t1_first_valid", 64'({m_axis_tvalid, busy}), 64'b11);
    // A start request while busy must be ignored, even with an illegal length.
    cfg_len = 16'd2000;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    wait_done(prev);
    check("t1_frame_cycles", 64'(last_hs_cyc - start_cyc + 1), 64'd4);
    check("t1_sb_empty", 64'(exp_q.size()), 64'd0);

    // 2: len=5, partial final beat.
    queue_frame(16'hA0A1, 16'hB0B1, 16'd5, -1);
    prev = done_cnt;
    launch(16'hA0A1, 16'hB0B1, 16'd5);
    wait_done(prev);
    check("t2_sb_empty", 64'(exp_q.size()), 64'd0);

    // 3: len=0, header only, payload side never ready.
    saw_sready = 0;
    queue_frame(16'h0001, 16'h0002, 16'd0, -1);
    prev = done_cnt;
    launch(16'h0001, 16'h0002, 16'd0);
    wait_done(prev);
    check("t3_sready_low", 64'(saw_sready), 64'd0);
    check("t3_sb_empty", 64'(exp_q.size()), 64'd0);

    // 4: oversize length rejected.
    base = m_hs_cnt;
    launch(16'h1111, 16'h2222, 16'd1473);
    check("t4_cfg_err", 64'({cfg_err, busy, m_axis_tvalid}), 64'b100);
    tick();
    check("t4_cfg_err_pulse", 64'({cfg_err, busy}), 64'b00);
    repeat (3) tick();
    check("t4_no_beats", 64'(m_hs_cnt - base), 64'd0);

    // Back-to-back: start held high through frame A, B accepted in done cycle.
    queue_frame(16'hC001, 16'hD001, 16'd8, -1);
    queue_frame(16'hC002, 16'hD002, 16'd3, -1);
    cfg_src_port = 16'hC001; cfg_dst_port = 16'hD001; cfg_len = 16'd8;
    cfg_start = 1'b1;
    tick();
    cfg_src_port = 16'hC002; cfg_dst_port = 16'hD002; cfg_len = 16'd3;
    prev = done_cnt;
    wait_done(prev);
    check("b2b_hdr0", 64'({m_axis_tvalid, m_axis_tdata}), 64'({1'b1, 32'hC002_D002}));
    cfg_start = 1'b0;
    prev = done_cnt;
    wait_done(prev);
    check("b2b_sb_empty", 64'(exp_q.size()), 64'd0);
    check("cfg_err_count", 64'(cfg_err_cnt), 64'd1);

    // Random frames with output stalls.
    rand_stall = 1;
    for (int f = 0; f < 6; f++) begin
      logic [15:0] l, s, d;
      l = 16'($urandom_range(0, 24));
      s = 16'($urandom);
      d = 16'($urandom);
      queue_frame(s, d, l, -1);
      prev = done_cnt;
      launch(s, d, l);
      wait_done(prev);
      check("rand_sb_empty", 64'(exp_q.size()), 64'd0);
    end

    // 5: reset during payload under stalls.
    queue_frame(16'h5555, 16'h6666, 16'd40, -1);
    base = m_hs_cnt;
    prev = done_cnt;
    launch(16'h5555, 16'h6666, 16'd40);
    n = 0;
    while (m_hs_cnt < base + 5 && n < 2000) begin
      tick();
      n++;
    end
    check("t5_mid_payload", 64'(m_hs_cnt >= base + 5), 64'd1);
    ARESETN = 1'b0;
    tick();
    check_quiet("t5_reset");
    exp_q.delete();
    pay_q.delete();
    tick();
    ARESETN = 1'b1;
    rand_stall = 0;
    repeat (4) tick();
    check("t5_no_done", 64'(done_cnt), 64'(prev));
    check("t5_idle", 64'({busy, m_axis_tvalid}), 64'd0);

    // 6: input tlast on the wrong beat; framing stays length-driven.
    queue_frame(16'h0707, 16'h0808, 16'd8, 0);
    prev = done_cnt;
    launch(16'h0707, 16'h0808, 16'd8);
    wait_done(prev);
    check("t6_sb_empty", 64'(exp_q.size()), 64'd0);
`ifdef UDP_LEN_CHECK_EN
    check("t6_len_err", 64'(len_err), 64'd1);
`else
    check("t6_len_err", 64'(len_err), 64'd0);
`endif
    queue_frame(16'h0909, 16'h0A0A, 16'd4, -1);
    prev = done_cnt;
    launch(16'h0909, 16'h0A0A, 16'd4);
    wait_done(prev);
`ifdef UDP_LEN_CHECK_EN
    check("t6_len_err_sticky", 64'(len_err), 64'd1);
`else
    check("t6_len_err_tied", 64'(len_err), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
